sprite_layer_gen: RTL and testbench

SPRITE_LAYER_GEN -- requirements
Module: sprite_layer_gen

---
 rtl/sprite_pkg.sv | 14 +
 rtl/sprite_hit.sv | 32 +++
 rtl/sprite_layer_gen.sv | 108 ++++++++++
 tb/tb_sprite_layer_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared widths and default geometry for the sprite layer generator.
package sprite_pkg;
  localparam int COORD_W   = 10;
  localparam int SUM_W     = 11;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int SPR_W_DEF = 30;
  localparam int SPR_H_DEF = 50;

  // True when two or more bits are set (clearing the lowest set bit leaves something).
  function automatic logic multi_hit(input logic [7:0] m);
    return (m & (m - 8'd1)) != 8'd0;
  endfunction
endpackage

// File: rtl/sprite_hit.sv
// Window compare for one sprite; edge sums carry an extra bit so a sprite near
// the right/bottom edge is clipped instead of wrapping back to column/row 0.
module sprite_hit
  import sprite_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF,
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF
) (
  input  logic [COORD_W-1:0] h_cnt,
  input  logic [COORD_W-1:0] v_cnt,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               en,
  output logic               hit
);

  logic [SUM_W-1:0] x_end;
  logic [SUM_W-1:0] y_end;
  logic             in_x;
  logic             in_y;
  logic             in_act;

  assign x_end  = {1'b0, x} + SUM_W'(SPR_W);
  assign y_end  = {1'b0, y} + SUM_W'(SPR_H);
  assign in_x   = (h_cnt >= x) && ({1'b0, h_cnt} < x_end);
  assign in_y   = (v_cnt >= y) && ({1'b0, v_cnt} < y_end);
  assign in_act = ({1'b0, h_cnt} < SUM_W'(H_ACT)) && ({1'b0, v_cnt} < SUM_W'(V_ACT));
  assign hit    = en && in_x && in_y && in_act;

endmodule

// File: rtl/sprite_layer_gen.sv
// Sprite layer generator: frame-shadowed sprite positions, registered priority
// layer select and hit mask, and per-frame sprite collision reporting.
module sprite_layer_gen
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 2,
  parameter int SPR_W   = SPR_W_DEF,
  parameter int SPR_H   = SPR_H_DEF,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int V_ACT   = V_ACT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [COORD_W-1:0]         h_cnt,
  input  logic [COORD_W-1:0]         v_cnt,
  input  logic [COORD_W*NUM_SPR-1:0] spr_x,
  input  logic [COORD_W*NUM_SPR-1:0] spr_y,
  input  logic [NUM_SPR-1:0]         spr_en,
  output logic [NUM_SPR:0]           layers,
  output logic [NUM_SPR-1:0]         hit_mask,
  output logic [NUM_SPR-1:0]         coll_frame,
  output logic                       coll_stb
);

  localparam int XW       = COORD_W * NUM_SPR;
  localparam int LAYERS_W = NUM_SPR + 1;

  logic                frame_tick;
  logic [XW-1:0]       x_sh_q, x_sh_d;
  logic [XW-1:0]       y_sh_q, y_sh_d;
  logic [NUM_SPR-1:0]  en_sh_q, en_sh_d;
  logic [NUM_SPR-1:0]  hit_d;
  logic [NUM_SPR-1:0]  hit_mask_q, hit_mask_d;
  logic [LAYERS_W-1:0] layers_q, layers_d;
  logic [NUM_SPR-1:0]  acc_q, acc_d;
  logic [NUM_SPR-1:0]  coll_frame_q, coll_frame_d;
  logic                coll_stb_q, coll_stb_d;
  logic [NUM_SPR-1:0]  coll_pix;

  assign frame_tick = (h_cnt == '0) && (v_cnt == '0);

  // The shadow next-value is also the effective position: live on the tick, held otherwise.
  always_comb begin
    x_sh_d  = frame_tick ? spr_x  : x_sh_q;
    y_sh_d  = frame_tick ? spr_y  : y_sh_q;
    en_sh_d = frame_tick ? spr_en : en_sh_q;
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
    sprite_hit #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .H_ACT (H_ACT),
      .V_ACT (V_ACT)
    ) u_sprite_hit (
      .h_cnt (h_cnt),
      .v_cnt (v_cnt),
      .x     (x_sh_d[COORD_W*g +: COORD_W]),
      .y     (y_sh_d[COORD_W*g +: COORD_W]),
      .en    (en_sh_d[g]),
      .hit   (hit_d[g])
    );
  end

  // Descending scan so the lowest-index hit sprite wins.
  always_comb begin
    layers_d = LAYERS_W'(1);
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_d[i]) layers_d = LAYERS_W'(1) << (i + 1);
    end
  end

  always_comb begin
    hit_mask_d   = hit_d;
    coll_pix     = multi_hit(8'(hit_d)) ? hit_d : '0;
    acc_d        = frame_tick ? coll_pix : (acc_q | coll_pix);
    coll_frame_d = frame_tick ? acc_q : coll_frame_q;
    coll_stb_d   = frame_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh_q       <= '0;
      y_sh_q       <= '0;
      en_sh_q      <= '0;
      hit_mask_q   <= '0;
      layers_q     <= LAYERS_W'(1);
      acc_q        <= '0;
      coll_frame_q <= '0;
      coll_stb_q   <= 1'b0;
    end else begin
      x_sh_q       <= x_sh_d;
      y_sh_q       <= y_sh_d;
      en_sh_q      <= en_sh_d;
      hit_mask_q   <= hit_mask_d;
      layers_q     <= layers_d;
      acc_q        <= acc_d;
      coll_frame_q <= coll_frame_d;
      coll_stb_q   <= coll_stb_d;
    end
  end

  assign layers     = layers_q;
  assign hit_mask   = hit_mask_q;
  assign coll_frame = coll_frame_q;
  assign coll_stb   = coll_stb_q;

endmodule

// File: tb/tb_sprite_layer_gen.sv
// Self-checking bench for sprite_layer_gen: directed scenarios plus randomized
// pixels checked against a rule-level reference model.
module tb_sprite_layer_gen;
  localparam int N     = 2;
  localparam int SPR_W = 30;
  localparam int SPR_H = 50;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  logic           clk;
  logic           rst_n;
  logic [9:0]     h_cnt, v_cnt;
  logic [10*N-1:0] spr_x, spr_y;
  logic [N-1:0]   spr_en;
  logic [N:0]     layers;
  logic [N-1:0]   hit_mask, coll_frame;
  logic           coll_stb;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int           sh_x[N];
  int           sh_y[N];
  logic [N-1:0] sh_en;
  logic [N-1:0] m_acc, m_hit, m_coll;
  logic [N:0]   m_layers;
  logic         m_stb;

  sprite_layer_gen #(.NUM_SPR(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_en     (spr_en),
    .layers     (layers),
    .hit_mask   (hit_mask),
    .coll_frame (coll_frame),
    .coll_stb   (coll_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {layers, hit_mask, coll_frame, coll_stb};
  endfunction

  function automatic logic [7:0] expv();
    return {m_layers, m_hit, m_coll, m_stb};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0;
      sh_y[i] = 0;
    end
    sh_en = '0; m_acc = '0; m_hit = '0; m_coll = '0; m_stb = 1'b0; m_layers = 3'b001;
  endtask

  task automatic set_spr(input int x0, input int y0, input int x1, input int y1, input logic [1:0] en);
    spr_x  = {10'(x1), 10'(x0)};
    spr_y  = {10'(y1), 10'(y0)};
    spr_en = en;
  endtask

  // Drive one pixel, clock it, and advance the model to what the outputs must show.
  task automatic step(input int h, input int v);
    logic [N-1:0] hits;
    logic [N-1:0] contrib;
    int nhit;
    int first;
    logic tick;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    tick = (h == 0) && (v == 0);
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        sh_x[i] = int'(spr_x[10*i +: 10]);
        sh_y[i] = int'(spr_y[10*i +: 10]);
      end
      sh_en = spr_en;
    end
    hits = '0; nhit = 0; first = -1;
    for (int i = 0; i < N; i++) begin
      if (sh_en[i] && h >= sh_x[i] && h < sh_x[i] + SPR_W && v >= sh_y[i] && v < sh_y[i] + SPR_H
          && h < H_ACT && v < V_ACT) begin
        hits[i] = 1'b1;
        nhit++;
        if (first < 0) first = i;
      end
    end
    contrib = (nhit >= 2) ? hits : '0;
    @(posedge clk);
    #1;
    m_hit = hits;
    m_layers = (first < 0) ? 3'b001 : (3'b001 << (first + 1));
    if (tick) begin
      m_coll = m_acc;
      m_acc  = contrib;
      m_stb  = 1'b1;
    end else begin
      m_acc = m_acc | contrib;
      m_stb = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; h_cnt = '0; v_cnt = '0;
    set_spr(0, 0, 0, 0, 2'b00);
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs() !== 8'b001_00_00_0) begin
      n_fail++; $display("FAIL reset_async: got %b exp %b", obs(), 8'b001_00_00_0);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs() !== 8'b001_00_00_0) begin
      n_fail++; $display("FAIL reset_held: got %b exp %b", obs(), 8'b001_00_00_0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(5 + i, 5);
      n_chk++;
      if (obs() !== expv() || coll_stb !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle: got %b exp %b", obs(), expv());
      end
    end
  endtask

  task automatic test_basic();
    int px[6] = '{0, 500, 529, 530, 110, 139};
    int py[6] = '{0, 100, 149, 149, 100, 149};
    logic [2:0] el[6] = '{3'bxxx, 3'b010, 3'b010, 3'b001, 3'b100, 3'b100};
    set_spr(500, 100, 110, 100, 2'b11);
    for (int k = 0; k < 6; k++) begin
      step(px[k], py[k]);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL basic_model: got %b exp %b at (%0d,%0d)", obs(), expv(), px[k], py[k]);
      end
      if (k > 0) begin
        n_chk++;
        if (layers !== el[k]) begin
          n_fail++; $display("FAIL basic_layers: got %b exp %b at (%0d,%0d)", layers, el[k], px[k], py[k]);
        end
      end
    end
  endtask

  task automatic test_overlap();
    set_spr(200, 200, 200, 200, 2'b11);
    step(0, 0);
    for (int k = 0; k < 4; k++) begin
      step(200 + k * 9, 200 + k * 16);
      n_chk++;
      if (obs() !== expv() || hit_mask !== 2'b11 || layers !== 3'b010) begin
        n_fail++; $display("FAIL overlap_pix: got %b exp %b", obs(), expv());
      end
    end
    step(300, 300);
    step(0, 0);
    n_chk++;
    if (coll_frame !== 2'b11 || coll_stb !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL overlap_report: got cf=%b stb=%b exp cf=11 stb=1", coll_frame, coll_stb);
    end
    step(400, 400);
    n_chk++;
    if (coll_stb !== 1'b0 || coll_frame !== 2'b11) begin
      n_fail++; $display("FAIL overlap_stb_width: got cf=%b stb=%b exp cf=11 stb=0", coll_frame, coll_stb);
    end
  endtask

  task automatic test_clip();
    int rows[3] = '{10, 30, 59};
    set_spr(630, 10, 0, 300, 2'b01);
    step(0, 0);
    for (int c = 620; c <= 650; c += 3) begin
      step(c, 30);
      n_chk++;
      if (obs() !== expv() || hit_mask[0] !== (c >= 630 && c <= 639)) begin
        n_fail++; $display("FAIL clip_right: got %b exp %b at col %0d", obs(), expv(), c);
      end
    end
    step(639, 59);
    n_chk++;
    if (hit_mask !== 2'b01) begin
      n_fail++; $display("FAIL clip_corner: got %b exp 01", hit_mask);
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 1; c < 20; c += 6) begin
        step(c, rows[r]);
        n_chk++;
        if (hit_mask !== 2'b00 || obs() !== expv()) begin
          n_fail++; $display("FAIL clip_nowrap: got %b exp 00 at (%0d,%0d)", hit_mask, c, rows[r]);
        end
      end
    end
    set_spr(1010, 1010, 0, 300, 2'b01);
    step(0, 0);
    for (int c = 0; c < 20; c += 4) begin
      step(c, 5);
      n_chk++;
      if (hit_mask !== 2'b00 || obs() !== expv()) begin
        n_fail++; $display("FAIL clip_wrap10: got %b exp 00 at col %0d", hit_mask, c);
      end
    end
  endtask

  task automatic test_midframe();
    int px[5] = '{300, 300, 300, 300, 300};
    int py[5] = '{120, 240, 120, 220, 260};
    logic ex[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    set_spr(300, 100, 0, 0, 2'b01);
    step(0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) set_spr(300, 200, 0, 0, 2'b01);
      step(px[k], py[k]);
      n_chk++;
      if (obs() !== expv() || hit_mask[0] !== ex[k]) begin
        n_fail++; $display("FAIL midframe_old: got %b exp %b at row %0d", obs(), expv(), py[k]);
      end
    end
    step(0, 0);
    step(300, 220);
    n_chk++;
    if (hit_mask[0] !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL midframe_new_in: got %b exp 1", hit_mask[0]);
    end
    step(300, 120);
    n_chk++;
    if (hit_mask[0] !== 1'b0 || obs() !== expv()) begin
      n_fail++; $display("FAIL midframe_new_out: got %b exp 0", hit_mask[0]);
    end
  endtask

  task automatic test_disabled();
    set_spr(50, 50, 60, 60, 2'b01);
    step(0, 0);
    step(70, 70);
    n_chk++;
    if (hit_mask !== 2'b01 || layers !== 3'b010 || obs() !== expv()) begin
      n_fail++; $display("FAIL disabled_hit: got hm=%b lay=%b exp hm=01 lay=010", hit_mask, layers);
    end
    step(0, 0);
    n_chk++;
    if (coll_frame !== 2'b00 || coll_stb !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL disabled_coll: got cf=%b stb=%b exp cf=00 stb=1", coll_frame, coll_stb);
    end
  endtask

  task automatic test_random();
    int x0, y0, x1, y1, h, v, sel, k;
    logic [1:0] en;
    for (int f = 0; f < 8; f++) begin
      x0 = (f == 7) ? $urandom_range(995, 1023) : $urandom_range(0, 660);
      y0 = (f == 6) ? $urandom_range(440, 1023) : $urandom_range(0, 470);
      x1 = x0 + $urandom_range(0, 60) - 30; if (x1 < 0) x1 = 0; if (x1 > 1023) x1 = 1023;
      y1 = y0 + $urandom_range(0, 90) - 45; if (y1 < 0) y1 = 0; if (y1 > 1023) y1 = 1023;
      en = (f % 2 == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      set_spr(x0, y0, x1, y1, en);
      step(0, 0);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL rand_tick: got %b exp %b frame %0d", obs(), expv(), f);
      end
      for (int p = 0; p < 150; p++) begin
        sel = $urandom_range(0, 9);
        k = $urandom_range(0, N - 1);
        if (sel < 6) begin
          h = sh_x[k] + $urandom_range(0, SPR_W + 10) - 5;
          v = sh_y[k] + $urandom_range(0, SPR_H + 10) - 5;
        end else if (sel < 8) begin
          h = $urandom_range(0, 20);
          v = sh_y[k] + $urandom_range(0, SPR_H);
        end else begin
          h = $urandom_range(0, 1023);
          v = $urandom_range(0, 600);
        end
        if (h < 0) h = 0; if (h > 1023) h = 1023;
        if (v < 0) v = 0; if (v > 1023) v = 1023;
        if (h == 0 && v == 0) h = 1;
        if ($urandom_range(0, 19) == 0)
          set_spr($urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023), 2'($urandom_range(0, 3)));
        step(h, v);
        n_chk++;
        if (obs() !== expv()) begin
          n_fail++; $display("FAIL rand_pix: got %b exp %b at (%0d,%0d) frame %0d", obs(), expv(), h, v, f);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_spr(200, 200, 200, 200, 2'b11);
    step(0, 0);
    step(210, 210);
    step(100, 300);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs() !== 8'b001_00_00_0) begin
      n_fail++; $display("FAIL resetmid_async: got %b exp %b", obs(), 8'b001_00_00_0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs() !== 8'b001_00_00_0) begin
      n_fail++; $display("FAIL resetmid_held: got %b exp %b", obs(), 8'b001_00_00_0);
    end
    @(negedge clk) rst_n = 1'b1;
    set_spr(100, 100, 400, 100, 2'b11);
    for (int k = 0; k < 4; k++) begin
      step(210, 310 + k);
      n_chk++;
      if (obs() !== expv() || coll_stb !== 1'b0) begin
        n_fail++; $display("FAIL resetmid_quiet: got %b exp %b", obs(), expv());
      end
    end
    step(0, 0);
    n_chk++;
    if (coll_stb !== 1'b1 || coll_frame !== 2'b00 || obs() !== expv()) begin
      n_fail++; $display("FAIL resetmid_report: got cf=%b stb=%b exp cf=00 stb=1", coll_frame, coll_stb);
    end
    step(110, 110);
    n_chk++;
    if (hit_mask !== 2'b01 || obs() !== expv()) begin
      n_fail++; $display("FAIL resetmid_resume: got %b exp 01", hit_mask);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_clip();
    test_midframe();
    test_disabled();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
